// File: rtl/quad_enc_pb_multi.sv
// quad_enc_pb_multi: N debounced quadrature channels with position counters,
// plus a debounced pushbutton classified into short/long events.
module quad_enc_pb_multi #(
    parameter int N_ENC      = 1,
    parameter int CNT_W      = 8,
    parameter int CNT_MAX    = 255,
    parameter int SAT_MODE   = 0,
    parameter int X4_MODE    = 0,
    parameter int DEB_LEN    = 16,
    parameter int LONG_TICKS = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_ENC-1:0]       enc_a,
    input  logic [N_ENC-1:0]       enc_b,
    input  logic                   pb_n,
    input  logic [N_ENC-1:0]       cnt_clr,
    output logic [N_ENC*CNT_W-1:0] cnt_o,
    output logic [N_ENC-1:0]       step_cw,
    output logic [N_ENC-1:0]       step_ccw,
    output logic [N_ENC-1:0]       enc_err,
    output logic                   pb_evt_valid,
    output logic [1:0]             pb_evt_type,
    input  logic                   pb_evt_ready,
    output logic                   pb_evt_drop
);

    localparam int NS = 2 * N_ENC + 1;
    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {PB_IDLE, PB_PRESSED, PB_HELD} pb_state_t;

    logic [NS-1:0] raw, init_lvl, sync1, sync2, deb;
    logic          deb_lvl [NS];
    logic [DW-1:0] deb_cnt [NS];

    logic [CNT_W-1:0] cnt [N_ENC];
    logic [1:0]       prv [N_ENC];
    logic             cw_q [N_ENC];
    logic             ccw_q [N_ENC];
    logic             err_q [N_ENC];

    pb_state_t     state, state_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          pressed, emit;
    logic [1:0]    emit_type;

    assign raw      = {pb_n, enc_b, enc_a};
    assign init_lvl = {1'b1, {(2 * N_ENC){1'b0}}};
    assign pressed  = ~deb[NS-1];

    // two-flop synchroniser on every raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= init_lvl;
            sync2 <= init_lvl;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_deb
        // accept a new level only after DEB_LEN consecutive differing cycles
        always_ff @(posedge clk) begin
            if (rst) begin
                deb_lvl[s] <= init_lvl[s];
                deb_cnt[s] <= '0;
            end else if (sync2[s] == deb_lvl[s]) begin
                deb_cnt[s] <= '0;
            end else if (deb_cnt[s] == DW'(DEB_LEN - 1)) begin
                deb_lvl[s] <= sync2[s];
                deb_cnt[s] <= '0;
            end else begin
                deb_cnt[s] <= deb_cnt[s] + 1'b1;
            end
        end
    end

    // pack per-signal debounced levels into a vector
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            deb[s] = deb_lvl[s];
        end
    end

    for (genvar i = 0; i < N_ENC; i++) begin : g_ch
        logic [1:0] cur;
        logic       cw, ccw, bad;

        assign cur = {deb[i], deb[N_ENC+i]};

        // classify the prev/current debounced {A,B} pair
        always_comb begin
            cw  = 1'b0;
            ccw = 1'b0;
            bad = ((cur ^ prv[i]) == 2'b11);
            if (X4_MODE != 0) begin
                case ({prv[i], cur})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: cw  = 1'b1;
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: ccw = 1'b1;
                    default: ;
                endcase
            end else begin
                cw  = (prv[i] == 2'b01) && (cur == 2'b00);
                ccw = (prv[i] == 2'b10) && (cur == 2'b00);
            end
        end

        // track state, count steps; clear beats a step, pulses still fire
        always_ff @(posedge clk) begin
            if (rst) begin
                prv[i]   <= 2'b00;
                cnt[i]   <= '0;
                cw_q[i]  <= 1'b0;
                ccw_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
            end else begin
                prv[i]   <= cur;
                cw_q[i]  <= cw;
                ccw_q[i] <= ccw;
                err_q[i] <= bad;
                if (cnt_clr[i]) begin
                    cnt[i] <= '0;
                end else if (cw) begin
                    if (cnt[i] == MAXV) cnt[i] <= (SAT_MODE != 0) ? MAXV : '0;
                    else                cnt[i] <= cnt[i] + 1'b1;
                end else if (ccw) begin
                    if (cnt[i] == '0) cnt[i] <= (SAT_MODE != 0) ? '0 : MAXV;
                    else              cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // flatten channel state onto the output ports
    always_comb begin
        cnt_o    = '0;
        step_cw  = '0;
        step_ccw = '0;
        enc_err  = '0;
        for (int i = 0; i < N_ENC; i++) begin
            cnt_o[i*CNT_W +: CNT_W] = cnt[i];
            step_cw[i]  = cw_q[i];
            step_ccw[i] = ccw_q[i];
            enc_err[i]  = err_q[i];
        end
    end

    // pushbutton FSM state and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PB_IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // press classification: long fires at threshold, short on early release
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        emit      = 1'b0;
        emit_type = 2'b00;
        case (state)
            PB_IDLE: begin
                if (pressed) begin
                    state_nxt = PB_PRESSED;
                    hold_nxt  = '0;
                end
            end
            PB_PRESSED: begin
                if (!pressed) begin
                    emit      = 1'b1;
                    emit_type = 2'b01;
                    state_nxt = PB_IDLE;
                end else if (hold == HW'(LONG_TICKS - 1)) begin
                    emit      = 1'b1;
                    emit_type = 2'b10;
                    state_nxt = PB_HELD;
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            PB_HELD: begin
                if (!pressed) state_nxt = PB_IDLE;
            end
            default: state_nxt = PB_IDLE;
        endcase
    end

    // one-deep event register; a new event while blocked is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_evt_valid <= 1'b0;
            pb_evt_type  <= 2'b00;
            pb_evt_drop  <= 1'b0;
        end else begin
            pb_evt_drop <= 1'b0;
            if (emit) begin
                if (!pb_evt_valid || pb_evt_ready) begin
                    pb_evt_valid <= 1'b1;
                    pb_evt_type  <= emit_type;
                end else begin
                    pb_evt_drop <= 1'b1;
                end
            end else if (pb_evt_valid && pb_evt_ready) begin
                pb_evt_valid <= 1'b0;
            end
        end
    end

endmodule
